// File: rtl/fetch_seq_pkg.sv
// fetch_seq shared definitions: opcodes, instruction field positions,
// sequencer state enum and the branch-taken rule.
package fetch_seq_pkg;

    localparam logic [2:0] OP_LW   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_MV   = 3'b010;
    localparam logic [2:0] OP_MVI  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SUBI = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic logic is_taken(
        input logic [2:0] op,
        input logic       zero
    );
        return (op == OP_JMP) || (op == OP_BEQ && zero);
    endfunction

endpackage

// File: rtl/fetch_seq_pc_next.sv
// pc_next: combinational next-PC calculator.
// Ports: pc, op, imm, zero_in in; next_pc out (PC+1, plus imm[1:0] if taken).
module pc_next
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [2:0]        op,
    input  logic [2:0]        imm,
    input  logic              zero_in,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] ofs;
    logic              unused_imm;

    // only the low two immediate bits form the branch offset
    assign unused_imm = imm[2];

    always_comb begin
        ofs = '0;
        if (is_taken(op, zero_in)) begin
            ofs = ADDR_W'(imm[1:0]);
        end
        next_pc = pc + ADDR_W'(1) + ofs;
    end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: two-state fetch/issue sequencer with PC and branch handling.
// Ports: clk, rst_n; imem_req/addr/ack/rdata memory side; instr_valid/ready,
// op/rd/imm, zero_in, pc datapath side. FETCH_SEQ_PERF_CNT_EN adds
// issue_cnt and taken_cnt.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [2:0]         op,
    output logic [1:0]         rd,
    output logic [2:0]         imm,
    input  logic               zero_in,
    output logic [ADDR_W-1:0]  pc
`ifdef FETCH_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        issue_cnt,
    output logic [15:0]        taken_cnt
`endif
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  next_pc;
    logic               run_q;
    logic               hs;

    assign op        = instr_q[OP_MSB:OP_LSB];
    assign rd        = instr_q[RD_MSB:RD_LSB];
    assign imm       = instr_q[IMM_MSB:IMM_LSB];
    assign pc        = pc_q;
    assign imem_addr = pc_q;

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc      (pc_q),
        .op      (op),
        .imm     (imm),
        .zero_in (zero_in),
        .next_pc (next_pc)
    );

    // run_q keeps the request low for the first edge after reset so a
    // stale ack left over from before reset cannot be taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        hs          = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req = run_q;
                if (run_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    hs      = 1'b1;
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
        endcase
    end

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [15:0] issue_cnt_q, taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else if (hs) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
            if (is_taken(op, zero_in)) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign taken_cnt = taken_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized and directed bench for fetch_seq against a
// behavioural program-flow model.
module tb_fetch_seq;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op;
    logic [1:0] rd;
    logic [2:0] imm;
    logic       zero_in;
    logic [7:0] pc;
`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [15:0] issue_cnt;
    logic [15:0] taken_cnt;
`endif

    fetch_seq #(
        .ADDR_W  (8),
        .INSTR_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .imm         (imm),
        .zero_in     (zero_in),
        .pc          (pc)
`ifdef FETCH_SEQ_PERF_CNT_EN
        ,
        .issue_cnt   (issue_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;
    logic [7:0] mem [256];
    int model_pc;
    int m_issue;
    int m_taken;
    int fetched [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 0);
        chk({tag, "_vld"}, 32'(instr_valid), 0);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_addr"}, 32'(imem_addr), 0);
        chk({tag, "_fields"}, 32'({op, rd, imm}), 0);
`ifdef FETCH_SEQ_PERF_CNT_EN
        chk({tag, "_icnt"}, 32'(issue_cnt), 0);
        chk({tag, "_tcnt"}, 32'(taken_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        @(negedge clk);
        chk_reset("rst_hold");
        rst_n    = 1'b1;
        model_pc = 0;
        m_issue  = 0;
        m_taken  = 0;
        fetched.delete();
    endtask

    task automatic fill_alu();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h80 | 8'(i % 32);
        end
    endtask

    task automatic run(input int n, input int ack_pct, input int rdy_pct,
                       input int zmode);
        logic pv;
        int   w;
        logic tk;
        pv = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("one_active", 32'(imem_req ^ instr_valid), 1);
            if (ack_pct == 100 && rdy_pct == 100 && i > 0) begin
                chk("alternate", 32'(instr_valid != pv), 1);
            end
            pv = instr_valid;
`ifdef FETCH_SEQ_PERF_CNT_EN
            chk("issue_cnt", 32'(issue_cnt), 32'(m_issue % 65536));
            chk("taken_cnt", 32'(taken_cnt), 32'(m_taken % 65536));
`endif
            imem_ack    = 1'b0;
            instr_ready = 1'b0;
            zero_in     = 1'($urandom % 2);
            imem_rdata  = 8'($urandom);
            if (imem_req) begin
                chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
                if (int'($urandom_range(99, 0)) < ack_pct) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    fetched.push_back(int'(imem_addr));
                end
            end else if (instr_valid) begin
                w = int'(mem[model_pc]);
                chk("issue_pc", 32'(pc), 32'(model_pc));
                chk("issue_op", 32'(op), 32'(w / 32));
                chk("issue_rd", 32'(rd), 32'((w / 8) % 4));
                chk("issue_imm", 32'(imm), 32'(w % 8));
                imem_ack = 1'($urandom % 2);
                if (int'($urandom_range(99, 0)) < rdy_pct) begin
                    instr_ready = 1'b1;
                    if (zmode != 2) zero_in = (zmode != 0);
                    tk = (w / 32 == 7) || (w / 32 == 6 && zero_in);
                    model_pc = (model_pc + 1 + (tk ? w % 4 : 0)) % 256;
                    m_issue++;
                    if (tk) m_taken++;
                end
            end
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        zero_in     = 1'b0;
        fill_alu();
        do_reset();

        // sequential ALU stream, zero-wait memory, ready always high
        run(10, 100, 100, 0);
        chk("n_seq", 32'(fetched.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", 32'(fetched[k]), 32'(k));
        end

        // jmp imm=2 at PC=5 lands on 8
        fill_alu();
        mem[5] = 8'b111_00_010;
        mem[10] = 8'b110_01_011;
        do_reset();
        run(24, 100, 100, 1);
        chk("n_jmp", 32'(fetched.size() >= 10), 1);
        chk("jmp_src", 32'(fetched[5]), 5);
        chk("jmp_tgt", 32'(fetched[6]), 8);
        chk("beq_src", 32'(fetched[8]), 10);
        chk("beq_taken", 32'(fetched[9]), 14);

        do_reset();
        run(24, 100, 100, 0);
        chk("n_beq_nt", 32'(fetched.size() >= 10), 1);
        chk("beq_not_taken", 32'(fetched[9]), 11);

        // stalled ack then stalled ready: single issue, fields stable
        fill_alu();
        mem[0] = 8'b011_01_011;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 1);
            chk("wait_addr", 32'(imem_addr), 0);
            chk("wait_vld", 32'(instr_valid), 0);
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[0];
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_ack   = 1'($urandom % 2);
            imem_rdata = 8'($urandom);
            zero_in    = 1'($urandom % 2);
            chk("stall_vld", 32'(instr_valid), 1);
            chk("stall_req", 32'(imem_req), 0);
            chk("stall_fields", 32'({op, rd, imm}), 32'(8'b011_01_011));
            if (i == 4) instr_ready = 1'b1;
        end
        @(negedge clk);
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        chk("post_req", 32'(imem_req), 1);
        chk("post_addr", 32'(imem_addr), 1);
        chk("post_vld", 32'(instr_valid), 0);
        @(negedge clk);
        chk("hold_addr", 32'(imem_addr), 1);
        chk("hold_vld", 32'(instr_valid), 0);
`ifdef FETCH_SEQ_PERF_CNT_EN
        chk("single_issue", 32'(issue_cnt), 1);
`endif

        // wrap: FC -> FE via jmp1, FE jmp3 -> 02
        for (int i = 0; i < 256; i++) mem[i] = 8'hE3;
        mem[8'hFC] = 8'hE1;
        do_reset();
        run(140, 100, 100, 2);
        chk("n_wrap1", 32'(fetched.size() >= 66), 1);
        chk("wrap_fe", 32'(fetched[64]), 32'h0FE);
        chk("wrap_02", 32'(fetched[65]), 2);

        // wrap: FC jmp2 -> FF, sequential FF -> 00
        mem[8'hFC] = 8'hE2;
        mem[8'hFF] = 8'h85;
        do_reset();
        run(140, 100, 100, 2);
        chk("n_wrap2", 32'(fetched.size() >= 66), 1);
        chk("wrap_ff", 32'(fetched[64]), 32'h0FF);
        chk("wrap_00", 32'(fetched[65]), 0);

        // reset during an outstanding request, ack left high across release
        fill_alu();
        do_reset();
        @(negedge clk);
        chk("pre_rst_req", 32'(imem_req), 1);
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk_reset("mid_fetch_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack_req", 32'(imem_req), 1);
        chk("late_ack_addr", 32'(imem_addr), 0);
        chk("late_ack_vld", 32'(instr_valid), 0);
        imem_ack = 1'b0;

        // random programs, random handshakes, resets at arbitrary points
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            do_reset();
            run(700, 30 + r * 20, 30 + ((r * 37) % 70), 2);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
- REQ-001 SHALL have parameter ADDR_W, default 8, program-counter and instruction-memory address width.
- REQ-002 SHALL have parameter INSTR_W, default 8, instruction width; fields are op=[7:5], rd=[4:3], imm=[2:0].
- REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
- REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have imem_req  output  1  instruction-memory read request.
- REQ-006 SHALL have imem_addr  output  ADDR_W  read address, equal to PC.
- REQ-007 SHALL have imem_ack  input  1  read data valid this cycle.
- REQ-008 SHALL have imem_rdata  input  INSTR_W  instruction word.
- REQ-009 SHALL have instr_valid  output  1  decoded fields presented to the control decoder and datapath.
- REQ-010 SHALL have instr_ready  input  1  the datapath accepts the instruction this cycle.
- REQ-011 SHALL have op  output  3, rd  output  2, imm  output  3: fields of the held instruction.
- REQ-012 SHALL have zero_in  input  1  selected register equals zero; sampled only at the issue handshake.
- REQ-013 SHALL have pc  output  ADDR_W  address of the held or in-flight instruction.

Function
- REQ-014 SHALL implement the FSM states FETCH and ISSUE.
- REQ-015 FETCH: imem_req=1, imem_addr=PC, both held stable until imem_ack; on ack, imem_rdata is latched and the FSM goes to ISSUE.
- REQ-016 imem_ack in the same cycle imem_req first rises SHALL be accepted (zero-wait memory); the minimum issue interval is 2 cycles per instruction.
- REQ-017 ISSUE: instr_valid=1, imem_req=0; op, rd and imm held stable until instr_valid && instr_ready.
- REQ-018 On the issue handshake the next PC SHALL be computed as follows.
  - op=3'b111 (jmp): PC+1+imm[1:0].
  - op=3'b110 (beq) with zero_in=1: PC+1+imm[1:0].
  - All other cases: PC+1.
- REQ-019 The FSM SHALL then return to FETCH.
- REQ-020 PC arithmetic SHALL be modulo 2^ADDR_W (8'hFF+1 wraps to 8'h00); the branch offset is zero-extended.
- REQ-021 imem_ack in ISSUE SHALL be ignored; zero_in outside the handshake SHALL be ignored.
- REQ-022 With instr_ready held high, the next fetch SHALL start the cycle after the handshake; no instruction is issued twice or skipped.

Reset
- REQ-023 While rst_n=0, outputs SHALL immediately take these values.
  - State FETCH, PC=0.
  - imem_req=0, instr_valid=0.
  - op, rd and imm all 0.
- REQ-024 The first imem_req SHALL rise on the first clock edge after rst_n deasserts, with imem_addr=0.
- REQ-025 Reset asserted mid-fetch or mid-issue SHALL abandon the transaction; a late imem_ack after reset release and before the first request SHALL be ignored.

Configuration
- REQ-026 Macro FETCH_SEQ_PERF_CNT_EN SHALL be the only compile-time option.
  - Defined: adds output issue_cnt (16 bits), which counts issue handshakes, resets to 0, wraps at 16'hFFFF, and adds output taken_cnt (16 bits), which counts taken jmp/beq.
  - Undefined: neither port nor counter exists, and all other behaviour is identical.

Structure
- REQ-027 The shared package SHALL hold:
  - opcode constants OP_LW=000, OP_SW=001, OP_MV=010, OP_MVI=011, OP_ADDI=100, OP_SUBI=101, OP_BEQ=110, OP_JMP=111;
  - the field bit positions;
  - the FSM state enum.
- REQ-028 The sub-module pc_next SHALL be a combinational next-PC calculator with inputs pc, op, imm, zero_in and output next_pc; it is instantiated once.

Verification
- REQ-029 Reset release, imem_ack tied high, sequential ALU instructions at addresses 0..3 -> imem_addr 0,1,2,3; instr_valid every 2nd cycle.
- REQ-030 Word 8'b111_00_010 (jmp, imm=2) fetched at PC=5 -> next imem_addr=8.
- REQ-031 beq 8'b110_01_011 at PC=10: zero_in=1 -> next address 14; zero_in=0 -> next address 11.
- REQ-032 instr_ready held low 5 cycles with imem_ack delayed 3 cycles -> fields stable, no extra imem_req, single issue.
- REQ-033 jmp imm=3 at PC=8'hFE -> next address 8'h02; sequential at 8'hFF -> next address 8'h00.
- REQ-034 rst_n pulsed low during FETCH with imem_req=1 -> imem_req drops asynchronously; after release imem_addr=0; with FETCH_SEQ_PERF_CNT_EN, issue_cnt=0.
